alu: RTL and testbench

//   16-bit integer ALU for the MIPS-style CPU datapath execute stage.

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_addsub.sv | 25 ++
 rtl/alu.sv | 91 +++++++++
 tb/tb_alu.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU: default data width and opcode encodings.
package alu_pkg;

  localparam int WIDTH_DEFAULT = 16;

  localparam logic [2:0] OP_ADDU = 3'b000;
  localparam logic [2:0] OP_ADDS = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_BNE  = 3'b101;

endpackage

// File: rtl/alu_addsub.sv
// WIDTH-bit ripple-style adder with optional B inversion, carry-in, carry-out and signed overflow.
module alu_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             invert_b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ov
);

  logic [WIDTH-1:0] b_eff;

  assign b_eff = invert_b ? ~b : b;

  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};

  // Overflow judged on the operands the adder actually sees, so subtract is covered too.
  assign ov = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: op mux and signed compare feeding a single output register stage.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
  input  logic [2:0]       Opcode,
  output logic [WIDTH-1:0] Out,
  output logic             Cout,
  output logic             Lt,
  output logic             Eq,
  output logic             Gt,
  output logic             Ov
);

  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             add_ov;
  logic             add_invert;

  logic [WIDTH-1:0] out_d;
  logic             cout_d;
  logic             ov_d;
  logic             lt_d;
  logic             eq_d;
  logic             gt_d;

  // Cin doubles as the subtract select for the signed op; unsigned add never inverts.
  assign add_invert = (Opcode == OP_ADDS) && Cin;

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a        (X),
    .b        (Y),
    .invert_b (add_invert),
    .cin      (Cin),
    .sum      (add_sum),
    .cout     (add_cout),
    .ov       (add_ov)
  );

  assign lt_d = $signed(X) < $signed(Y);
  assign eq_d = (X == Y);
  assign gt_d = $signed(X) > $signed(Y);

  always_comb begin
    out_d  = '0;
    cout_d = 1'b0;
    ov_d   = 1'b0;
    case (Opcode)
      OP_ADDU: begin
        out_d  = add_sum;
        cout_d = add_cout;
        ov_d   = add_cout;
      end
      OP_ADDS: begin
        out_d  = add_sum;
        cout_d = add_cout;
        ov_d   = add_ov;
      end
      OP_AND:  out_d = X & Y;
      OP_OR:   out_d = X | Y;
      OP_SLT:  out_d = {{(WIDTH-1){1'b0}}, lt_d};
      OP_BNE:  out_d = {{(WIDTH-1){1'b0}}, ~eq_d};
      default: out_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Out  <= '0;
      Cout <= 1'b0;
      Lt   <= 1'b0;
      Eq   <= 1'b0;
      Gt   <= 1'b0;
      Ov   <= 1'b0;
    end else begin
      Out  <= out_d;
      Cout <= cout_d;
      Lt   <= lt_d;
      Eq   <= eq_d;
      Gt   <= gt_d;
      Ov   <= ov_d;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors plus randomized ops against an integer reference model.
module tb_alu;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cin;
  logic [2:0]   op;
  logic [W-1:0] out;
  logic         cout;
  logic         lt;
  logic         eq;
  logic         gt;
  logic         ov;

  int checks;
  int failures;

  // Expected vector layout: {Out, Cout, Lt, Eq, Gt, Ov}
  logic [W+4:0] exp_q[$];
  logic [W+4:0] got;

  assign got = {out, cout, lt, eq, gt, ov};

  alu dut (
    .clk    (clk),
    .reset  (reset),
    .X      (x),
    .Y      (y),
    .Cin    (cin),
    .Opcode (op),
    .Out    (out),
    .Cout   (cout),
    .Lt     (lt),
    .Eq     (eq),
    .Gt     (gt),
    .Ov     (ov)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the operation's meaning.
  function automatic logic [W+4:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic [2:0] o);
    int ua, ub, sa, sb, r;
    logic [W-1:0] res;
    logic co, ovf;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = 0;
    res = '0;
    co = 1'b0;
    ovf = 1'b0;
    case (o)
      3'd0: begin
        r   = ua + ub + int'(c);
        res = r[W-1:0];
        co  = (r > 65535);
        ovf = co;
      end
      3'd1: begin
        if (!c) begin
          r  = sa + sb;
          co = (ua + ub) > 65535;
        end else begin
          r  = sa - sb;
          co = (ua >= ub);
        end
        res = r[W-1:0];
        ovf = (r > 32767) || (r < -32768);
      end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = (sa < sb) ? 16'd1 : 16'd0;
      3'd5: res = (ua != ub) ? 16'd1 : 16'd0;
      default: res = '0;
    endcase
    return {res, co, sa < sb, sa == sb, sa > sb, ovf};
  endfunction

  // driver: apply one operation, then sample just after the capturing edge
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic [2:0] o);
    x   = a;
    y   = b;
    cin = c;
    op  = o;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    x = 16'h1234; y = 16'h0001; cin = 1'b1; op = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h expected=%h", got, {(W+5){1'b0}});
    end
    // reset must win over live inputs
    x = 16'h7FFF; y = 16'h8000; cin = 1'b1; op = 3'd1;
    @(posedge clk);
    #1;
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL reset_overrides got=%h expected=%h", got, {(W+5){1'b0}});
    end
  endtask

  task automatic test_first_op();
    reset = 1'b0;
    drive(16'd200, 16'd300, 1'b0, 3'd0);
    checks++;
    if (out !== 16'd500) begin
      failures++;
      $display("FAIL first_op_out got=%0d expected=500", out);
    end
    checks++;
    if ({cout, ov, lt, eq, gt} !== 5'b00100) begin
      failures++;
      $display("FAIL first_op_flags got={cout,ov,lt,eq,gt}=%b expected=00100", {cout, ov, lt, eq, gt});
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [2:0]   o;
    logic [W-1:0] exp_out;
    logic         exp_ov;
  } vec_t;

  task automatic test_directed();
    vec_t v[17];
    v[0]  = '{16'd200,   16'hFFFE, 1'b0, 3'd0, 16'd198,   1'b1};
    v[1]  = '{16'd200,   16'hFFFE, 1'b1, 3'd0, 16'd199,   1'b1};
    v[2]  = '{16'd200,   16'd300,  1'b1, 3'd0, 16'd501,   1'b0};
    v[3]  = '{16'd200,   16'd300,  1'b1, 3'd1, 16'hFF9C,  1'b0};
    v[4]  = '{16'hFF9C,  16'd300,  1'b1, 3'd1, 16'hFE70,  1'b0};
    v[5]  = '{16'd200,   16'hFF9C, 1'b1, 3'd1, 16'd300,   1'b0};
    v[6]  = '{16'd32000, 16'd10000,1'b0, 3'd1, 16'hA410,  1'b1};
    v[7]  = '{16'd10000, 16'h8000, 1'b1, 3'd1, 16'hA710,  1'b1};
    v[8]  = '{16'd1,     16'd32800,1'b1, 3'd1, 16'd32737, 1'b0};
    v[9]  = '{16'h8888,  16'hFFFF, 1'b0, 3'd2, 16'h8888,  1'b0};
    v[10] = '{16'h8888,  16'hFFFF, 1'b0, 3'd3, 16'hFFFF,  1'b0};
    v[11] = '{16'h0000,  16'hFFFF, 1'b1, 3'd2, 16'h0000,  1'b0};
    v[12] = '{16'hFF38,  16'd100,  1'b0, 3'd4, 16'd1,     1'b0};
    v[13] = '{16'd1,     16'hFFFF, 1'b0, 3'd4, 16'd0,     1'b0};
    v[14] = '{16'd200,   16'd200,  1'b0, 3'd4, 16'd0,     1'b0};
    v[15] = '{16'hFF38,  16'hFF38, 1'b0, 3'd5, 16'd0,     1'b0};
    v[16] = '{16'd1,     16'hFFFF, 1'b0, 3'd5, 16'd1,     1'b0};
    foreach (v[i]) begin
      drive(v[i].a, v[i].b, v[i].c, v[i].o);
      checks++;
      if (out !== v[i].exp_out) begin
        failures++;
        $display("FAIL directed_out[%0d] got=%h expected=%h", i, out, v[i].exp_out);
      end
      checks++;
      if (ov !== v[i].exp_ov) begin
        failures++;
        $display("FAIL directed_ov[%0d] got=%b expected=%b", i, ov, v[i].exp_ov);
      end
      checks++;
      if (got !== model(v[i].a, v[i].b, v[i].c, v[i].o)) begin
        failures++;
        $display("FAIL directed_model[%0d] got=%h expected=%h", i, got,
                 model(v[i].a, v[i].b, v[i].c, v[i].o));
      end
    end
    // explicit compare-flag boundaries called out for SLT
    drive(16'd1, 16'hFFFF, 1'b0, 3'd4);
    checks++;
    if ({lt, eq, gt} !== 3'b001) begin
      failures++;
      $display("FAIL slt_gt_flag got=%b expected=001", {lt, eq, gt});
    end
    drive(16'd200, 16'd200, 1'b0, 3'd4);
    checks++;
    if ({lt, eq, gt} !== 3'b010) begin
      failures++;
      $display("FAIL slt_eq_flag got=%b expected=010", {lt, eq, gt});
    end
  endtask

  task automatic test_reserved();
    for (int o = 6; o < 8; o++) begin
      drive(16'hFFFF, 16'h0001, 1'b1, 3'(o));
      checks++;
      if ({out, cout, ov} !== {16'h0000, 2'b00}) begin
        failures++;
        $display("FAIL reserved_op%0d got out=%h cout=%b ov=%b expected out=0000 cout=0 ov=0", o, out, cout, ov);
      end
    end
  endtask

  // scoreboard-driven back-to-back random operations
  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    logic c;
    logic [2:0] o;
    logic [W+4:0] exp;
    for (int n = 0; n < 500; n++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
      if ($urandom_range(0, 9) == 0) a = 16'h8000;
      if ($urandom_range(0, 9) == 0) b = 16'h7FFF;
      c = 1'($urandom_range(0, 1));
      o = 3'($urandom_range(0, 7));
      exp_q.push_back(model(a, b, c, o));
      drive(a, b, c, o);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random[%0d] op=%0d x=%h y=%h cin=%b got=%h expected=%h", n, o, a, b, c, got, exp);
      end
      checks++;
      if (!$onehot({lt, eq, gt})) begin
        failures++;
        $display("FAIL random_onehot[%0d] got=%b expected exactly one set", n, {lt, eq, gt});
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(16'd5, 16'd7, 1'b0, 3'd0);
    reset = 1'b1;
    drive(16'hFFFF, 16'hFFFF, 1'b1, 3'd0);
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL reset_mid got=%h expected=%h", got, {(W+5){1'b0}});
    end
    reset = 1'b0;
    drive(16'hFFFF, 16'hFFFF, 1'b1, 3'd0);
    checks++;
    if (got !== model(16'hFFFF, 16'hFFFF, 1'b1, 3'd0)) begin
      failures++;
      $display("FAIL reset_resume got=%h expected=%h", got, model(16'hFFFF, 16'hFFFF, 1'b1, 3'd0));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset = 1'b1;
    x = '0; y = '0; cin = 1'b0; op = '0;
    test_reset();
    test_first_op();
    test_directed();
    test_reserved();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
